priority_decoder: RTL and testbench

PRIORITY_DECODER -- requirements
Module: priority_decoder

---
 rtl/priority_pkg.sv | 23 ++
 rtl/onehot_to_bin.sv | 35 +++
 rtl/priority_decoder.sv | 157 +++++++++++++++
 tb/tb_priority_decoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_pkg.sv
//------------------------------------------------------------------------------
// priority_pkg -- shared constants, helper and pair classification type for
//                 the priority decoder.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package priority_pkg;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int ptr_size(input int width);
        return $clog2(width);
    endfunction

    typedef enum logic [1:0] {
        PC_VALID = 2'd0,
        PC_ZERO  = 2'd1,
        PC_ERROR = 2'd2
    } pair_class_t;

endpackage

`default_nettype wire

// File: rtl/onehot_to_bin.sv
//------------------------------------------------------------------------------
// onehot_to_bin -- one-hot to binary index via per-bit OR reduction, plus an
//                  exactly-one-bit-set flag.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module onehot_to_bin
    import priority_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PTR_SIZE = ptr_size(WIDTH)
) (
    input  logic [WIDTH-1:0]    onehot,
    output logic [PTR_SIZE-1:0] idx,
    output logic                onehot_ok
);

    // Index bit b is the OR of every mask bit whose position has bit b set.
    for (genvar b = 0; b < PTR_SIZE; b++) begin : g_idx_bit
        logic [WIDTH-1:0] w_sel;
        for (genvar i = 0; i < WIDTH; i++) begin : g_sel
            if (((i >> b) & 1) == 1) begin : g_on
                assign w_sel[i] = onehot[i];
            end else begin : g_off
                assign w_sel[i] = 1'b0;
            end
        end
        assign idx[b] = |w_sel;
    end

    assign onehot_ok = (onehot != '0) && ((onehot & (onehot - WIDTH'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/priority_decoder.sv
//------------------------------------------------------------------------------
// priority_decoder -- two-stage valid/ready pipeline turning a pair of one-hot
//                     masks into indices, span and zero/error flags.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module priority_decoder
    import priority_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    localparam int PTR_SIZE = ptr_size(WIDTH)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [WIDTH-1:0]    data_left_i,
    input  logic [WIDTH-1:0]    data_right_i,
    input  logic                data_val_i,
    output logic                data_ready_o,
    output logic [PTR_SIZE-1:0] left_idx_o,
    output logic [PTR_SIZE-1:0] right_idx_o,
    output logic [PTR_SIZE:0]   span_o,
    output logic                zero_o,
    output logic                err_o,
    output logic                data_val_o,
    input  logic                data_ready_i
);

    localparam int SPAN_W = PTR_SIZE + 1;

    logic                run_q,       run_d;
    logic                s1_vld_q,    s1_vld_d;
    logic [WIDTH-1:0]    s1_left_q,   s1_left_d;
    logic [WIDTH-1:0]    s1_right_q,  s1_right_d;
    logic                s2_vld_q,    s2_vld_d;
    logic [PTR_SIZE-1:0] left_idx_q,  left_idx_d;
    logic [PTR_SIZE-1:0] right_idx_q, right_idx_d;
    logic [SPAN_W-1:0]   span_q,      span_d;
    logic                zero_q,      zero_d;
    logic                err_q,       err_d;

    logic                w_s2_adv;
    logic                w_s1_adv;
    logic                w_in_fire;
    logic [PTR_SIZE-1:0] w_left_idx;
    logic [PTR_SIZE-1:0] w_right_idx;
    logic                w_left_ok;
    logic                w_right_ok;
    logic [SPAN_W-1:0]   w_span;
    pair_class_t         w_class;

    onehot_to_bin #(.WIDTH(WIDTH), .PTR_SIZE(PTR_SIZE)) u_left_dec (
        .onehot    (s1_left_q),
        .idx       (w_left_idx),
        .onehot_ok (w_left_ok)
    );

    onehot_to_bin #(.WIDTH(WIDTH), .PTR_SIZE(PTR_SIZE)) u_right_dec (
        .onehot    (s1_right_q),
        .idx       (w_right_idx),
        .onehot_ok (w_right_ok)
    );

    // run_q keeps the input closed until the first edge after reset release.
    assign w_s2_adv     = !s2_vld_q || data_ready_i;
    assign w_s1_adv     = !s1_vld_q || w_s2_adv;
    assign data_ready_o = run_q && w_s1_adv;
    assign w_in_fire    = data_val_i && data_ready_o;

    assign w_span = {1'b0, w_left_idx} - {1'b0, w_right_idx} + SPAN_W'(1);

    always_comb begin
        w_class = PC_ERROR;
        if ((s1_left_q == '0) && (s1_right_q == '0)) begin
            w_class = PC_ZERO;
        end else if (w_left_ok && w_right_ok && (w_left_idx >= w_right_idx)) begin
            w_class = PC_VALID;
        end
    end

    always_comb begin
        run_d       = 1'b1;
        s1_vld_d    = s1_vld_q;
        s1_left_d   = s1_left_q;
        s1_right_d  = s1_right_q;
        s2_vld_d    = s2_vld_q;
        left_idx_d  = left_idx_q;
        right_idx_d = right_idx_q;
        span_d      = span_q;
        zero_d      = zero_q;
        err_d       = err_q;

        if (w_s1_adv) begin
            s1_vld_d = w_in_fire;
            if (w_in_fire) begin
                s1_left_d  = data_left_i;
                s1_right_d = data_right_i;
            end
        end

        // An empty stage 2 loads all-zero fields so idle outputs read as 0.
        if (w_s2_adv) begin
            s2_vld_d    = s1_vld_q;
            left_idx_d  = '0;
            right_idx_d = '0;
            span_d      = '0;
            zero_d      = 1'b0;
            err_d       = 1'b0;
            if (s1_vld_q) begin
                case (w_class)
                    PC_VALID: begin
                        left_idx_d  = w_left_idx;
                        right_idx_d = w_right_idx;
                        span_d      = w_span;
                    end
                    PC_ZERO:  zero_d = 1'b1;
                    default:  err_d  = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_left_q   <= '0;
            s1_right_q  <= '0;
            s2_vld_q    <= 1'b0;
            left_idx_q  <= '0;
            right_idx_q <= '0;
            span_q      <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            run_q       <= run_d;
            s1_vld_q    <= s1_vld_d;
            s1_left_q   <= s1_left_d;
            s1_right_q  <= s1_right_d;
            s2_vld_q    <= s2_vld_d;
            left_idx_q  <= left_idx_d;
            right_idx_q <= right_idx_d;
            span_q      <= span_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign data_val_o  = s2_vld_q;
    assign left_idx_o  = left_idx_q;
    assign right_idx_o = right_idx_q;
    assign span_o      = span_q;
    assign zero_o      = zero_q;
    assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_priority_decoder.sv
//------------------------------------------------------------------------------
// tb_priority_decoder -- scoreboard bench for priority_decoder (WIDTH=16).
//                        Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_priority_decoder;

    localparam int WIDTH = 16;
    localparam int PS    = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic [WIDTH-1:0]  data_left_i = '0;
    logic [WIDTH-1:0]  data_right_i = '0;
    logic              data_val_i = 1'b0;
    logic              data_ready_o;
    logic [PS-1:0]     left_idx_o;
    logic [PS-1:0]     right_idx_o;
    logic [PS:0]       span_o;
    logic              zero_o;
    logic              err_o;
    logic              data_val_o;
    logic              data_ready_i = 1'b0;

    priority_decoder #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .data_left_i  (data_left_i),
        .data_right_i (data_right_i),
        .data_val_i   (data_val_i),
        .data_ready_o (data_ready_o),
        .left_idx_o   (left_idx_o),
        .right_idx_o  (right_idx_o),
        .span_o       (span_o),
        .zero_o       (zero_o),
        .err_o        (err_o),
        .data_val_o   (data_val_o),
        .data_ready_i (data_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [PS-1:0] l;
        logic [PS-1:0] r;
        logic [PS:0]   span;
        logic          z;
        logic          e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_in   = 0;
    logic mon_en = 1'b0;
    logic last_acc = 1'b0;
    logic stall_prev = 1'b0;
    exp_t held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: count set bits, locate them by scanning, apply the class rules.
    function automatic exp_t model(input logic [WIDTH-1:0] lm, input logic [WIDTH-1:0] rm);
        exp_t x;
        int li, ri;
        x  = '0;
        li = -1;
        ri = -1;
        if (lm == 0 && rm == 0) begin
            x.z = 1'b1;
            return x;
        end
        if ($countones(lm) == 1 && $countones(rm) == 1) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (lm[i]) li = i;
                if (rm[i]) ri = i;
            end
            if (li >= ri) begin
                x.l    = PS'(li);
                x.r    = PS'(ri);
                x.span = (PS+1)'(li - ri + 1);
                return x;
            end
        end
        x.e = 1'b1;
        return x;
    endfunction

    task automatic rand_pair(output logic [WIDTH-1:0] lm, output logic [WIDTH-1:0] rm);
        int k, a, b, hi, lo;
        k  = $urandom_range(0, 9);
        a  = $urandom_range(0, WIDTH-1);
        b  = $urandom_range(0, WIDTH-1);
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        lm = '0;
        rm = '0;
        case (k)
            0:       begin lm = '0; rm = '0; end
            6:       begin lm = WIDTH'(1) << lo; rm = WIDTH'(1) << hi; end
            7:       begin lm = WIDTH'($urandom); rm = WIDTH'(1) << lo; end
            8:       begin if (a[0]) lm = WIDTH'(1) << a; else rm = WIDTH'(1) << b; end
            9:       begin lm = WIDTH'($urandom); rm = WIDTH'($urandom); end
            default: begin lm = WIDTH'(1) << hi; rm = WIDTH'(1) << lo; end
        endcase
    endtask

    // Monitor: everything observed mid-cycle describes the transfers of the coming edge.
    always @(negedge clk_i) begin
        exp_t cur, e;
        int   occ;
        last_acc = rst_n_i && data_val_i && data_ready_o;
        if (!rst_n_i || !mon_en) begin
            stall_prev = 1'b0;
        end else begin
            cur = {left_idx_o, right_idx_o, span_o, zero_o, err_o};
            occ = sb.size();
            chk("ready_vs_occupancy", 64'(data_ready_o), 64'((occ < 2) || data_ready_i));
            if (stall_prev) begin
                chk("hold_valid", 64'(data_val_o), 64'(1));
                chk("hold_word", 64'(cur), 64'(held));
            end
            if (data_val_o) begin
                if (data_ready_i) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%0h required=none at %0t", cur, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("word", 64'(cur), 64'(e));
                    end
                end
            end else begin
                chk("idle_zero", 64'(cur), 64'(0));
            end
            stall_prev = data_val_o && !data_ready_i;
            held       = cur;
            if (data_val_i && data_ready_o) begin
                sb.push_back(model(data_left_i, data_right_i));
                n_in++;
            end
        end
    end

    task automatic directed(input string name, input logic [WIDTH-1:0] lm, input logic [WIDTH-1:0] rm,
                            input int el, input int er, input int es, input int ez, input int ee);
        data_ready_i = 1'b1;
        @(posedge clk_i); #1;
        data_left_i  = lm;
        data_right_i = rm;
        data_val_i   = 1'b1;
        @(posedge clk_i); #1;
        data_val_i   = 1'b0;
        @(posedge clk_i); #1;
        chk({name, "_val"},  64'(data_val_o),  64'(1));
        chk({name, "_lidx"}, 64'(left_idx_o),  64'(el));
        chk({name, "_ridx"}, 64'(right_idx_o), 64'(er));
        chk({name, "_span"}, 64'(span_o),      64'(es));
        chk({name, "_zero"}, 64'(zero_o),      64'(ez));
        chk({name, "_err"},  64'(err_o),       64'(ee));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] lm, rm;
        int sent, cyc;

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_val_o",   64'(data_val_o),   64'(0));
        chk("reset_ready_o", 64'(data_ready_o), 64'(0));
        chk("reset_span",    64'(span_o),       64'(0));
        rst_n_i = 1'b1;
        chk("ready_before_first_edge", 64'(data_ready_o), 64'(0));
        @(posedge clk_i); #1;
        chk("ready_after_first_edge", 64'(data_ready_o), 64'(1));
        mon_en = 1'b1;

        directed("full_span", 16'h8000, 16'h0001, 15, 0, 16, 0, 0);
        directed("same_bit",  16'h0010, 16'h0010, 4, 4, 1, 0, 0);
        directed("zero_pair", 16'h0000, 16'h0000, 0, 0, 0, 1, 0);
        directed("multi_bit", 16'h0003, 16'h0001, 0, 0, 0, 0, 1);
        directed("reversed",  16'h0002, 16'h0008, 0, 0, 0, 0, 1);
        directed("one_zero",  16'h0100, 16'h0000, 0, 0, 0, 0, 1);

        // Eight-word burst with a three-cycle downstream stall in the middle.
        @(posedge clk_i); #1;
        sent = 0;
        data_left_i  = 16'h0010;
        data_right_i = 16'h0001;
        data_val_i   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i); #1;
            if (last_acc && sent < 8) begin
                sent++;
                if (sent < 8) begin
                    data_left_i  = WIDTH'(1) << (sent + 4);
                    data_right_i = WIDTH'(1) << sent;
                end else begin
                    data_val_i = 1'b0;
                end
            end
            data_ready_i = !(c >= 3 && c < 6);
        end
        chk("burst_sent", 64'(sent), 64'(8));
        chk("burst_drained", 64'(sb.size()), 64'(0));

        // Reset between edges with two words in flight.
        data_ready_i = 1'b0;
        @(posedge clk_i); #1;
        data_left_i = 16'h0040; data_right_i = 16'h0002; data_val_i = 1'b1;
        @(posedge clk_i); #1;
        data_left_i = 16'h0400; data_right_i = 16'h0004;
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        chk("inflight_count", 64'(sb.size()), 64'(2));
        chk("inflight_full_ready", 64'(data_ready_o), 64'(0));
        @(negedge clk_i); #2;
        mon_en  = 1'b0;
        rst_n_i = 1'b0;
        #1;
        chk("async_rst_val",   64'(data_val_o),   64'(0));
        chk("async_rst_ready", 64'(data_ready_o), 64'(0));
        chk("async_rst_lidx",  64'(left_idx_o),   64'(0));
        sb.delete();
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        chk("rerelease_ready_before_edge", 64'(data_ready_o), 64'(0));
        @(posedge clk_i); #1;
        chk("rerelease_ready", 64'(data_ready_o), 64'(1));
        mon_en = 1'b1;
        data_ready_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        chk("no_output_after_reset", 64'(data_val_o), 64'(0));

        // Random traffic with random backpressure.
        n_in = 0;
        cyc  = 0;
        while (n_in < 10000 && cyc < 60000) begin
            @(posedge clk_i); #1;
            cyc++;
            if (!data_val_i || last_acc) begin
                if ($urandom_range(0, 99) < 85) begin
                    rand_pair(lm, rm);
                    data_left_i  = lm;
                    data_right_i = rm;
                    data_val_i   = 1'b1;
                end else begin
                    data_val_i = 1'b0;
                end
            end
            data_ready_i = ($urandom_range(0, 99) < 70);
        end
        chk("random_count", 64'(n_in >= 10000), 64'(1));

        @(posedge clk_i); #1;
        data_val_i   = 1'b0;
        data_ready_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("final_drain", 64'(sb.size()), 64'(0));
        chk("final_idle",  64'(data_val_o), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
